// File: rtl/pow_5_pipe_arb.sv
// Round-robin arbiter and scheduler that shares one pipelined fifth-power
// datapath among n_req requesters. Each issued argument carries its requester
// ID down a tag shift register that lines up with the datapath's final stage,
// so every returning result is routed back to the requester that issued it.
module pow_5_pipe_arb #(
    parameter int w     = 8,  // argument and result width
    parameter int n_req = 4,  // number of requesters (2..8)
    parameter int lat   = 5   // datapath latency, issue sampled -> result valid
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [n_req-1:0]   req_vld,
    input  logic [n_req*w-1:0] req_n,
    output logic [n_req-1:0]   req_rdy,
    output logic               pipe_arg_vld,
    output logic [w-1:0]       pipe_n,
    input  logic               pipe_res_vld,
    input  logic [w-1:0]       pipe_res,
    output logic [n_req-1:0]   out_vld,
    output logic [w-1:0]       out_res,
    output logic               busy,
    output logic               err
);

    localparam int id_w = (n_req > 1) ? $clog2(n_req) : 1;
    // Work stays counted from the accept edge until its tail tag retires,
    // which spans one cycle more than the datapath latency.
    localparam int cnt_w = $clog2(lat + 2);

    typedef struct packed {
        logic            vld;
        logic [id_w-1:0] id;
    } tag_t;

    logic [id_w-1:0]  ptr_q, ptr_d;
    logic             pipe_arg_vld_q, pipe_arg_vld_d;
    logic [w-1:0]     pipe_n_q, pipe_n_d;
    logic [id_w-1:0]  issue_id_q, issue_id_d;
    tag_t             tag_q [lat];
    tag_t             tail;
    logic [n_req-1:0] out_vld_q, out_vld_d;
    logic [w-1:0]     out_res_q, out_res_d;
    logic             err_q, err_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;

    logic             grant_vld;
    logic [id_w-1:0]  grant_id;

    assign tail = tag_q[lat-1];

    // Pick the first valid requester scanning upward from the pointer with wrap.
    always_comb begin
        int              idx_i;
        logic [id_w-1:0] idx;
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant_vld = 1'b0;
        grant_id  = '0;
        req_rdy   = '0;
        idx_i     = 0;
        idx       = '0;
        for (int k = 0; k < n_req; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= n_req) begin
                idx_i = idx_i - n_req;
            end
            idx = id_w'(idx_i);
            if (!grant_vld && en && rst_n && req_vld[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        if (grant_vld) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    // Next state for issue, return path, error flag and in-flight counter.
    always_comb begin
        ptr_d          = ptr_q;
        pipe_arg_vld_d = grant_vld;
        pipe_n_d       = pipe_n_q;
        issue_id_d     = issue_id_q;
        if (grant_vld) begin
            ptr_d      = (grant_id == id_w'(n_req - 1)) ? '0 : grant_id + 1'b1;
            pipe_n_d   = req_n[int'(grant_id)*w +: w];
            issue_id_d = grant_id;
        end

        out_vld_d = '0;
        out_res_d = out_res_q;
        if (pipe_res_vld && tail.vld) begin
            out_vld_d[tail.id] = 1'b1;
            out_res_d          = pipe_res;
        end

        // Any disagreement between the datapath valid and the tag is sticky.
        err_d = err_q | (pipe_res_vld ^ tail.vld);

        unique case ({grant_vld, tail.vld})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous active-low reset; tags shift every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            ptr_q          <= '0;
            pipe_arg_vld_q <= 1'b0;
            pipe_n_q       <= '0;
            issue_id_q     <= '0;
            out_vld_q      <= '0;
            out_res_q      <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            // NOTE: the tag array is reset because stale valid bits would be routed as results after a flush.
            for (int k = 0; k < lat; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q          <= ptr_d;
            pipe_arg_vld_q <= pipe_arg_vld_d;
            pipe_n_q       <= pipe_n_d;
            issue_id_q     <= issue_id_d;
            out_vld_q      <= out_vld_d;
            out_res_q      <= out_res_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            // Entry 0 follows the issue register, so the tail meets the
            // datapath's final stage in the same cycle.
            tag_q[0] <= '{vld: pipe_arg_vld_q, id: issue_id_q};
            for (int k = 1; k < lat; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign pipe_arg_vld = pipe_arg_vld_q;
    assign pipe_n       = pipe_n_q;
    assign out_vld      = out_vld_q;
    assign out_res      = out_res_q;
    assign err          = err_q;
    assign busy         = (cnt_q != '0);

endmodule
